// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI slave with all SPI-side inputs synchronised into clk.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   mode              : {CPOL, CPHA}, captured only while deselected
//   sclk, ss_n, mosi  : SPI master signals (asynchronous to clk)
//   miso, miso_oe     : serial data out and its tri-state enable
//   tx_data/valid/ready : one-word TX holding register handshake
//   rx_data/valid/ready : last received word handshake
// Build option: SPI_SLAVE_SYNC_OVERRUN_EN adds rx_overrun. A word completing
// while the previous one is unread then overwrites rx_data. Without the option
// the new word is dropped and the old rx_data is kept.
module spi_slave_sync #(
  parameter int unsigned BITS        = 8,
  parameter int unsigned LSB_FIRST   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      mode,
  input  logic            sclk,
  input  logic            ss_n,
  input  logic            mosi,
  output logic            miso,
  output logic            miso_oe,
  input  logic [BITS-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [BITS-1:0] rx_data,
  output logic            rx_valid,
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
  output logic            rx_overrun,
`endif
  input  logic            rx_ready
);

  localparam int unsigned CW = (BITS > 1) ? $clog2(BITS) : 1;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic            sclk_s, ss_s, mosi_s;
  logic            sclk_q, ss_q;
  logic [1:0]      mode_q;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] rx_shift, rx_next;
  logic [BITS-1:0] tx_shift, hold, load_word;
  logic            hold_full, miso_q;
  logic            selected, ss_fall, rise, fall;
  logic            leading, trailing, sample_edge, shift_edge, last_bit, word_start;

  function automatic logic [BITS-1:0] shift_out(input logic [BITS-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic out_bit(input logic [BITS-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[BITS-1];
  endfunction

  function automatic logic [BITS-1:0] shift_in(input logic [BITS-1:0] r, input logic b);
    return (LSB_FIRST != 0) ? {b, r[BITS-1:1]} : {r[BITS-2:0], b};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  always_comb begin
    sclk_s      = sclk_sync[SYNC_STAGES-1];
    ss_s        = ss_sync[SYNC_STAGES-1];
    mosi_s      = mosi_sync[SYNC_STAGES-1];
    selected    = ~ss_s;
    ss_fall     = ss_q & ~ss_s;
    rise        = sclk_s & ~sclk_q;
    fall        = ~sclk_s & sclk_q;
    leading     = mode_q[1] ? fall : rise;
    trailing    = mode_q[1] ? rise : fall;
    sample_edge = selected & (mode_q[0] ? trailing : leading);
    shift_edge  = selected & (mode_q[0] ? leading : trailing);
    last_bit    = (cnt == CW'(BITS - 1));
    word_start  = selected & (ss_fall | (sample_edge & last_bit));
    rx_next     = shift_in(rx_shift, mosi_s);
    load_word   = hold_full ? hold : '0;
  end

  assign tx_ready = ~hold_full;
  assign miso_oe  = ~ss_s;
  assign miso     = miso_oe & miso_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q    <= 1'b0;
      ss_q      <= 1'b1;
      mode_q    <= 2'b00;
      cnt       <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_shift  <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      miso_q    <= 1'b0;
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
      rx_overrun <= 1'b0;
`endif
    end else begin
      sclk_q <= sclk_s;
      ss_q   <= ss_s;
      if (ss_s) mode_q <= mode;
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
      rx_overrun <= 1'b0;
`endif
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end

      if (!selected) begin
        cnt      <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
        miso_q   <= 1'b0;
      end else begin
        if (sample_edge) begin
          rx_shift <= rx_next;
          if (last_bit) begin
            cnt <= '0;
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
            rx_data  <= rx_next;
            rx_valid <= 1'b1;
            if (rx_valid && !rx_ready) rx_overrun <= 1'b1;
`else
            if (!rx_valid || rx_ready) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
            end
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // CPHA=0 presents the first bit at word start, so the trailing edge
        // right after a wrap (cnt==0) must not shift. CPHA=1 presents every
        // bit, including the first, on a leading edge.
        if (word_start) begin
          if (hold_full) hold_full <= 1'b0;
          if (!mode_q[0]) begin
            miso_q   <= out_bit(load_word);
            tx_shift <= shift_out(load_word);
          end else begin
            tx_shift <= load_word;
          end
        end else if (shift_edge && (mode_q[0] || cnt != '0)) begin
          miso_q   <= out_bit(tx_shift);
          tx_shift <= shift_out(tx_shift);
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
module tb_spi_slave_sync;

  localparam time T = 80ns;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       sclk, ss_n, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
  logic       rx_overrun;
  int         ovr_cnt = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [1:0] m;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  spi_slave_sync #(.BITS(8), .LSB_FIRST(0), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
    .rx_overrun(rx_overrun),
`endif
    .rx_ready(rx_ready)
  );

  always #5ns clk = ~clk;

`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
  always @(posedge clk) if (rx_overrun) ovr_cnt++;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the bench model: miso quiet while disabled,
  // each consumed word matches the next word the master sent, and an
  // unconsumed word never changes (default build keeps the old word).
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (!miso_oe) check("miso_idle", {31'b0, miso}, 32'h0);
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) check("rx_unexpected", {24'b0, rx_data}, 32'hFFFF_FFFF);
        else check("rx_word", {24'b0, rx_data}, {24'b0, exp_rx.pop_front()});
      end
`ifndef SPI_SLAVE_SYNC_OVERRUN_EN
      if (rx_valid && prev_hold) check("rx_stable", {24'b0, rx_data}, {24'b0, prev_data});
`endif
      prev_hold = rx_valid && !rx_ready;
      prev_data = rx_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic setup_mode(input logic [1:0] md);
    m    = md;
    mode = md;
    sclk = md[1];
    repeat (6) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] w);
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (tx_ready) break;
      @(negedge clk);
    end
    if (!tx_ready) begin
      check("tx_ready_timeout", 32'h0, 32'h1);
      tx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      exp_tx.push_back(w);
    end
  endtask

  task automatic select_slave();
    ss_n = 1'b0;
    #T;
    check("miso_oe_on", {31'b0, miso_oe}, 32'h1);
  endtask

  task automatic deselect_slave();
    #T;
    ss_n = 1'b1;
    repeat (6) @(negedge clk);
    check("miso_oe_off", {31'b0, miso_oe}, 32'h0);
  endtask

  // Master side of one word (MSB first), sampling miso on the opposite edge
  // from the one on which it changes mosi.
  task automatic shift_word(input logic [7:0] w, input int nbits, output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!m[0]) begin
        mosi = w[7-i];
        #T; sclk = ~m[1]; got[7-i] = miso;
        #T; sclk = m[1];
      end else begin
        #T; sclk = ~m[1]; mosi = w[7-i];
        #T; sclk = m[1]; got[7-i] = miso;
      end
    end
  endtask

  task automatic do_word(input logic [7:0] w, input bit push_rx, output logic [7:0] got);
    logic [7:0] e;
    if (push_rx) exp_rx.push_back(w);
    shift_word(w, 8, got);
    e = (exp_tx.size() != 0) ? exp_tx.pop_front() : 8'h00;
    check("miso_word", {24'b0, got}, {24'b0, e});
  endtask

  task automatic check_reset_outputs();
    check("rst_miso",     {31'b0, miso},     32'h0);
    check("rst_miso_oe",  {31'b0, miso_oe},  32'h0);
    check("rst_tx_ready", {31'b0, tx_ready}, 32'h1);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'h0);
    check("rst_rx_data",  {24'b0, rx_data},  32'h0);
  endtask

  logic [7:0] got;

  initial begin
    rst_n = 1'b0; mode = 2'b00; m = 2'b00; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Mode 0 basic transfer
    setup_mode(2'b00);
    load_tx(8'h65);
    select_slave();
    do_word(8'hC5, 1, got);
    deselect_slave();
    check("m0_rx_literal",   {24'b0, rx_data}, 32'hC5);
    check("m0_miso_literal", {24'b0, got},     32'h65);

    // Mode 3
    setup_mode(2'b11);
    load_tx(8'h65);
    select_slave();
    do_word(8'hC5, 1, got);
    deselect_slave();
    check("m3_rx_literal",   {24'b0, rx_data}, 32'hC5);
    check("m3_miso_literal", {24'b0, got},     32'h65);

    // Mode 1, with the mode input changed while selected (must be ignored)
    setup_mode(2'b01);
    load_tx(8'h65);
    select_slave();
    mode = 2'b10;
    do_word(8'hC5, 1, got);
    deselect_slave();
    check("m1_rx_literal",   {24'b0, rx_data}, 32'hC5);
    check("m1_miso_literal", {24'b0, got},     32'h65);

    // Back-to-back words, second TX word loaded while the first shifts
    setup_mode(2'b00);
    load_tx(8'h5A);
    select_slave();
    fork
      begin
        logic [7:0] g1, g2;
        do_word(8'hA5, 1, g1);
        do_word(8'h3C, 1, g2);
        check("b2b_miso0", {24'b0, g1}, 32'h5A);
        check("b2b_miso1", {24'b0, g2}, 32'h81);
      end
      load_tx(8'h81);
    join
    deselect_slave();
    check("b2b_rx_literal", {24'b0, rx_data}, 32'h3C);
    check("b2b_rx_drained", exp_rx.size(), 32'h0);

    // Partial word aborted by ss_n, then a clean word
    setup_mode(2'b00);
    select_slave();
    shift_word(8'hFF, 3, got);
    deselect_slave();
    check("partial_no_valid", {31'b0, rx_valid}, 32'h0);
    load_tx(8'h3C);
    select_slave();
    do_word(8'h96, 1, got);
    deselect_slave();
    check("partial_rx_literal", {24'b0, rx_data}, 32'h96);

    // Two words with rx_ready low
    rx_ready = 1'b0;
    select_slave();
    do_word(8'h11, 0, got);
    do_word(8'h22, 0, got);
    deselect_slave();
    check("ovr_valid", {31'b0, rx_valid}, 32'h1);
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
    check("ovr_rx_data", {24'b0, rx_data}, 32'h22);
    check("ovr_pulses", ovr_cnt, 32'h1);
    exp_rx.push_back(8'h22);
`else
    check("ovr_rx_data", {24'b0, rx_data}, 32'h11);
    exp_rx.push_back(8'h11);
`endif
    @(negedge clk);
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("ovr_drained", exp_rx.size(), 32'h0);
    check("ovr_valid_clear", {31'b0, rx_valid}, 32'h0);

    // Reset in the middle of a word, with the holding register full
    load_tx(8'h77);
    select_slave();
    load_tx(8'h33);
    shift_word(8'hF0, 4, got);
    check("pre_rst_tx_full", {31'b0, tx_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    ss_n = 1'b1;
    exp_tx.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    setup_mode(2'b00);
    load_tx(8'h65);
    select_slave();
    do_word(8'hC5, 1, got);
    deselect_slave();
    check("post_rst_rx_literal",   {24'b0, rx_data}, 32'hC5);
    check("post_rst_miso_literal", {24'b0, got},     32'h65);
    check("final_rx_drained", exp_rx.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
